riscv_pipe_ctrl: RTL and testbench

Pipeline sequencing and hazard controller for the riscv IF/ID/EX datapath.
- Tracks in-flight destination registers in EX and WB with a small scoreboard.
- Drives the IF `bubble` (PC hold), ID->EX NOP insertion, the front-end flush on taken branches, and the operand-forwarding selects for EX.
- Sits beside riscv_if/riscv_id/riscv_ex. Owns no datapath state, only control.

---
 rtl/riscv_pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline sequencing and hazard control for the riscv IF/ID/EX datapath.
// Keeps a two-entry destination scoreboard and drives stall, kill, flush and forwarding selects.
module riscv_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             ex_busy,
  input  logic             br_taken,
  output logic             bubble,
  output logic             id_kill,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // WB results are always ready, so the WB entry carries no load flag.
  logic             sb_ex_v_r;
  logic [4:0]       sb_ex_rd_r;
  logic             sb_ex_ld_r;
  logic             sb_wb_v_r;
  logic [4:0]       sb_wb_rd_r;
  logic [2:0]       fcnt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic       br_acc_s;
  logic       ex_hit_rs1_s;
  logic       ex_hit_rs2_s;
  logic       load_use_s;
  logic       issue_s;
  logic       bubble_s;
  logic       id_kill_s;
  logic       flush_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  function automatic logic sb_match(input logic v, input logic [4:0] sb_rd,
                                    input logic [4:0] rs, input logic use_rs);
    return v & use_rs & (sb_rd == rs) & (rs != 5'd0);
  endfunction

  // A pending load in EX cannot forward; the youngest non-load writer wins.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic wb_hit);
    logic [1:0] sel;
    if (ex_hit && !ex_ld) begin
      sel = 2'd1;
    end else if (wb_hit) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign br_acc_s     = br_taken & ~ex_busy;
  assign ex_hit_rs1_s = sb_match(sb_ex_v_r, sb_ex_rd_r, id_rs1, id_use_rs1);
  assign ex_hit_rs2_s = sb_match(sb_ex_v_r, sb_ex_rd_r, id_rs2, id_use_rs2);
  assign load_use_s   = (ex_hit_rs1_s | ex_hit_rs2_s) & sb_ex_ld_r & id_valid;

  // Stall / kill / flush arbitration; redirects override every stall source.
  always_comb begin
    bubble_s  = 1'b0;
    id_kill_s = 1'b0;
    flush_s   = 1'b0;
    if (rst) begin
      bubble_s  = 1'b0;
      id_kill_s = 1'b0;
      flush_s   = 1'b0;
    end else if (br_acc_s || (fcnt_r != 3'd0)) begin
      flush_s   = 1'b1;
      id_kill_s = 1'b1;
    end else if (ex_busy) begin
      bubble_s  = 1'b1;
    end else if (load_use_s) begin
      bubble_s  = 1'b1;
      id_kill_s = 1'b1;
    end else begin
      bubble_s  = 1'b0;
      id_kill_s = 1'b0;
    end
  end

  // Operand forwarding selects, forced to the regfile while in reset.
  always_comb begin
    fwd_a_s = 2'd0;
    fwd_b_s = 2'd0;
    if (rst) begin
      fwd_a_s = 2'd0;
      fwd_b_s = 2'd0;
    end else begin
      fwd_a_s = fwd_sel(ex_hit_rs1_s, sb_ex_ld_r,
                        sb_match(sb_wb_v_r, sb_wb_rd_r, id_rs1, id_use_rs1));
      fwd_b_s = fwd_sel(ex_hit_rs2_s, sb_ex_ld_r,
                        sb_match(sb_wb_v_r, sb_wb_rd_r, id_rs2, id_use_rs2));
    end
  end

  assign issue_s = id_valid & ~id_kill_s & ~flush_s & (id_rd != 5'd0);

  // Scoreboard advance; everything freezes while EX is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex_v_r  <= 1'b0;
      sb_ex_rd_r <= 5'd0;
      sb_ex_ld_r <= 1'b0;
      sb_wb_v_r  <= 1'b0;
      sb_wb_rd_r <= 5'd0;
    end else if (!ex_busy) begin
      sb_wb_v_r  <= sb_ex_v_r;
      sb_wb_rd_r <= sb_ex_rd_r;
      sb_ex_v_r  <= issue_s;
      sb_ex_rd_r <= id_rd;
      sb_ex_ld_r <= id_is_load;
    end else begin
      sb_ex_v_r  <= sb_ex_v_r;
      sb_wb_v_r  <= sb_wb_v_r;
    end
  end

  // Flush window counter; a new accepted branch restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_r <= 3'd0;
    end else if (br_acc_s) begin
      fcnt_r <= FLUSH_LOAD;
    end else if (fcnt_r != 3'd0) begin
      fcnt_r <= fcnt_r - 3'd1;
    end else begin
      fcnt_r <= 3'd0;
    end
  end

  // Saturating count of bubble cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (bubble_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bubble      = bubble_s;
  assign id_kill     = id_kill_s;
  assign flush       = flush_s;
  assign fwd_a       = fwd_a_s;
  assign fwd_b       = fwd_b_s;
  assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Self-checking bench for riscv_pipe_ctrl: vector table through an expected-value queue,
// plus hand sequences for reset mid-flush, reset mid-load-stall and counter saturation.
module tb_riscv_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       ex_busy;
  logic       br_taken;
  logic       bubble;
  logic       id_kill;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [7:0] stall_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       busy;
    logic       br;
    logic       e_bub;
    logic       e_kill;
    logic       e_flush;
    logic       chk_fwd;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic [7:0] e_sc;
  } vec_t;

  vec_t tbl[19];
  vec_t exp_q[$];

  riscv_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_busy(ex_busy), .br_taken(br_taken),
    .bubble(bubble), .id_kill(id_kill), .flush(flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic busy, input logic br,
                              input logic bub, input logic kill, input logic fl,
                              input logic cf, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [7:0] sc);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd; t.ld = ld;
    t.busy = busy; t.br = br; t.e_bub = bub; t.e_kill = kill; t.e_flush = fl;
    t.chk_fwd = cf; t.e_fa = fa; t.e_fb = fb; t.e_sc = sc;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1;
    id_use_rs2 = t.u2; id_rd = t.rd; id_is_load = t.ld; ex_busy = t.busy;
    br_taken = t.br;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bubble"}, int'(bubble), 0);
    chk({tag, ".id_kill"}, int'(id_kill), 0);
    chk({tag, ".flush"}, int'(flush), 0);
    chk({tag, ".fwd_a"}, int'(fwd_a), 0);
    chk({tag, ".fwd_b"}, int'(fwd_b), 0);
    chk({tag, ".stall_count"}, int'(stall_count), 0);
  endtask

  // Drive one cycle, sample at the falling edge, end #1 past the next rising edge.
  task automatic apply(input vec_t t, input string tag);
    vec_t e;
    drive(t);
    exp_q.push_back(t);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".bubble"}, int'(bubble), int'(e.e_bub));
    chk({tag, ".id_kill"}, int'(id_kill), int'(e.e_kill));
    chk({tag, ".flush"}, int'(flush), int'(e.e_flush));
    chk({tag, ".stall_count"}, int'(stall_count), int'(e.e_sc));
    if (e.chk_fwd) begin
      chk({tag, ".fwd_a"}, int'(fwd_a), int'(e.e_fa));
      chk({tag, ".fwd_b"}, int'(fwd_b), int'(e.e_fb));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              v rs1 rs2 u1 u2 rd ld bz br  bub kil fl cf fa fb sc
    tbl[0]  = mk(1, 0,  0,  1, 0, 5, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // addi x5
    tbl[1]  = mk(1, 5,  5,  1, 1, 6, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0); // add x6,x5,x5
    tbl[2]  = mk(1, 5,  0,  1, 1, 9, 0, 0, 0,  0, 0, 0, 1, 2, 0, 0); // x5 from WB
    tbl[3]  = mk(1, 5,  5,  1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // x5 retired
    tbl[4]  = mk(1, 0,  0,  1, 0, 7, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0); // lw x7
    tbl[5]  = mk(1, 7,  0,  1, 1, 8, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0); // load-use
    tbl[6]  = mk(1, 7,  0,  1, 1, 8, 0, 0, 0,  0, 0, 0, 1, 2, 0, 1); // retry, WB fwd
    tbl[7]  = mk(1, 8,  0,  1, 0, 10, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1); // taken branch
    tbl[8]  = mk(1, 8,  0,  1, 0, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1); // flush tail
    tbl[9]  = mk(1, 10, 8,  1, 1, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); // killed rd
    tbl[10] = mk(1, 11, 11, 1, 1, 12, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1); // busy 1
    tbl[11] = mk(1, 11, 11, 1, 1, 12, 0, 1, 1, 1, 0, 0, 1, 1, 1, 2); // busy 2, br ignored
    tbl[12] = mk(1, 11, 11, 1, 1, 12, 0, 1, 0, 1, 0, 0, 1, 1, 1, 3); // busy 3
    tbl[13] = mk(1, 11, 11, 1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4); // busy done
    tbl[14] = mk(1, 0,  0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 4); // load to x0
    tbl[15] = mk(1, 0,  0,  1, 1, 13, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4); // read x0, lw x13
    tbl[16] = mk(1, 0,  0,  0, 0, 13, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4); // alu x13
    tbl[17] = mk(1, 13, 13, 1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 4); // EX beats WB
    tbl[18] = mk(0, 13, 0,  1, 1, 14, 0, 0, 0, 0, 0, 0, 1, 2, 0, 4); // idle ID, WB fwd

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while the flush counter is at 1, with x5 still in WB.
    apply(mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4), "midflush.issue");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 4), "midflush.br");
    drive(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("midflush.pre.flush", int'(flush), 1);
    rst = 1'b1;
    #1;
    check_zero("midflush.rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "midflush.after");

    // Reset during a load-use stall.
    apply(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), "midload.lw");
    drive(mk(1, 7, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("midload.pre.bubble", int'(bubble), 1);
    chk("midload.pre.id_kill", int'(id_kill), 1);
    rst = 1'b1;
    #1;
    check_zero("midload.rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(1, 7, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "midload.after");

    // 300 busy cycles saturate the 8-bit counter.
    for (int i = 0; i < 300; i++) begin
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, (i < 255) ? 8'(i) : 8'd255),
            $sformatf("sat%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'd255), "sat.hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
